// File: rtl/fpmul_arb_pkg.sv
// Shared types and helpers for the shared 12-bit FP multiplier arbiter.
package fpmul_arb_pkg;
  localparam int FP_W = 12;
  typedef logic [FP_W-1:0] fp12_t;

  // One-hot input gives its bit index; callers guarantee at most one bit set.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/fpmul_share_arb_if.sv
// Requester and multiplier-side bus of fpmul_share_arb; slave = arbiter, master = clients/multiplier.
interface fpmul_share_arb_if import fpmul_arb_pkg::*; #(
  parameter int N = 4
) ();
  logic  [N-1:0] req_valid;
  logic  [N-1:0] req_ready;
  fp12_t [N-1:0] req_a;
  fp12_t [N-1:0] req_b;
  logic  [N-1:0] rsp_valid;
  fp12_t         rsp_data;
  logic          mul_valid_in;
  fp12_t         mul_a;
  fp12_t         mul_b;
  fp12_t         mul_result;
  logic          mul_valid_out;
  logic          busy;
  logic          err;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, mul_valid_out,
    output req_ready, rsp_valid, rsp_data, mul_valid_in, mul_a, mul_b, busy, err
  );
  modport master (
    output req_valid, req_a, req_b, mul_result, mul_valid_out,
    input  req_ready, rsp_valid, rsp_data, mul_valid_in, mul_a, mul_b, busy, err
  );
endinterface

// File: rtl/fpmul_rr_arbiter.sv
// Combinational round-robin arbiter: priority starts at last+1 and wraps modulo N.
module fpmul_rr_arbiter import fpmul_arb_pkg::*; #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(last) + k) % N);
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign gnt_idx = IW'(onehot_to_idx(8'(gnt)));
endmodule

// File: rtl/fpmul_share_arb.sv
// Shares one fixed-latency FP12 multiplier between N requesters with an in-order tag FIFO.
// Optional FPMUL_ARB_STATS_EN adds per-requester saturating grant counters on grant_cnt.
module fpmul_share_arb import fpmul_arb_pkg::*; #(
  parameter int N       = 4,
  parameter int MUL_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fpmul_share_arb_if.slave    bus
`ifdef FPMUL_ARB_STATS_EN
  ,
  output logic [N-1:0][15:0]  grant_cnt
`endif
);
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || MUL_LAT < 1) begin : g_bad_cfg
    $error("fpmul_share_arb: DEPTH must be >= 2 and MUL_LAT >= 1");
  end

  logic [IW-1:0]            r_last;
  logic [DEPTH-1:0][IW-1:0] r_tag;
  logic [AW-1:0]            r_wp, r_rp;
  logic [AW:0]              r_cnt;
  logic                     r_mul_vld, r_err;
  fp12_t                    r_mul_a, r_mul_b, r_rsp_data;
  logic [N-1:0]             r_rsp_vld;

  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_gnt_idx;
  logic          w_full, w_push, w_pop, w_spur;

  // A retire in the same cycle does not free a slot: full looks only at r_cnt.
  assign w_full = (r_cnt == (AW+1)'(DEPTH));

  fpmul_rr_arbiter #(.N(N)) u_arb (
    .req     (bus.req_valid),
    .last    (r_last),
    .en      (rst_n & ~w_full),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_push = |w_gnt;
  assign w_pop  = bus.mul_valid_out & (r_cnt != '0);
  assign w_spur = bus.mul_valid_out & (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= IW'(N-1);
      r_tag      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_mul_vld  <= 1'b0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_mul_vld <= w_push;
      if (w_push) begin
        r_last       <= w_gnt_idx;
        r_mul_a      <= bus.req_a[w_gnt_idx];
        r_mul_b      <= bus.req_b[w_gnt_idx];
        r_tag[r_wp]  <= w_gnt_idx;
        r_wp         <= r_wp + 1'b1;
      end
      r_rsp_vld <= w_pop ? (N'(1) << r_tag[r_rp]) : '0;
      if (w_pop) begin
        r_rsp_data <= bus.mul_result;
        r_rp       <= r_rp + 1'b1;
      end
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      if (w_spur) r_err <= 1'b1;
    end
  end

  assign bus.req_ready    = w_gnt;
  assign bus.mul_valid_in = r_mul_vld;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_mul_b;
  assign bus.rsp_valid    = r_rsp_vld;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.err          = r_err;
  assign bus.busy         = (r_cnt != '0) | r_mul_vld | (|r_rsp_vld);

`ifdef FPMUL_ARB_STATS_EN
  for (genvar g = 0; g < N; g++) begin : g_stat
    logic [15:0] r_gcnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            r_gcnt <= '0;
      else if (w_gnt[g] && r_gcnt != 16'hFFFF) r_gcnt <= r_gcnt + 16'd1;
    end
    assign grant_cnt[g] = r_gcnt;
  end
`endif
endmodule

// File: tb/tb_fpmul_share_arb.sv
// Directed bench: dut0 (MUL_LAT=1, DEPTH=4) and dut1 (MUL_LAT=3, DEPTH=2) with pass-through multiplier models.
module tb_fpmul_share_arb;
  import fpmul_arb_pkg::*;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spur0 = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fpmul_share_arb_if #(.N(N)) b0 ();
  fpmul_share_arb_if #(.N(N)) b1 ();
`ifdef FPMUL_ARB_STATS_EN
  logic [N-1:0][15:0] gcnt0, gcnt1;
`endif

  fpmul_share_arb #(.N(N), .MUL_LAT(1), .DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
`ifdef FPMUL_ARB_STATS_EN
    , .grant_cnt(gcnt0)
`endif
  );
  fpmul_share_arb #(.N(N), .MUL_LAT(3), .DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
`ifdef FPMUL_ARB_STATS_EN
    , .grant_cnt(gcnt1)
`endif
  );

  // Multiplier models return operand A after MUL_LAT cycles, sharing rst_n.
  logic  m0_vld;
  fp12_t m0_res;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin m0_vld <= 1'b0; m0_res <= '0; end
    else begin m0_vld <= b0.mul_valid_in; m0_res <= b0.mul_a; end
  assign b0.mul_valid_out = m0_vld | spur0;
  assign b0.mul_result    = m0_res;

  logic  [2:0] m1_vld;
  fp12_t [2:0] m1_res;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin m1_vld <= '0; m1_res <= '0; end
    else begin
      m1_vld <= {m1_vld[1:0], b1.mul_valid_in};
      m1_res <= {m1_res[1:0], b1.mul_a};
    end
  assign b1.mul_valid_out = m1_vld[2];
  assign b1.mul_result    = m1_res[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    b0.req_valid = '0;
    b1.req_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] fs_exp;
    b0.req_valid = '0; b0.req_a = '0; b0.req_b = '0;
    b1.req_valid = '0; b1.req_a = '0; b1.req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with requests present to show req_ready is held low
    b0.req_valid = 4'hF; #1;
    chk("rst_ready",   b0.req_ready, 0);
    chk("rst_mvld",    b0.mul_valid_in, 0);
    chk("rst_mul_a",   b0.mul_a, 0);
    chk("rst_rsp_vld", b0.rsp_valid, 0);
    chk("rst_rsp_dat", b0.rsp_data, 0);
    chk("rst_busy",    b0.busy, 0);
    chk("rst_err",     b0.err, 0);
    b0.req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single op from requester 2
    b0.req_a[2] = 12'h3C0; b0.req_b[2] = 12'h3C0; b0.req_valid = 4'b0100; #1;
    chk("t1_ready", b0.req_ready, 4'b0100);
    tick(); b0.req_valid = '0;
    chk("t1_issue", b0.mul_valid_in, 1);
    chk("t1_mul_a", b0.mul_a, 12'h3C0);
    chk("t1_mul_b", b0.mul_b, 12'h3C0);
    tick();
    chk("t1_rsp_early", b0.rsp_valid, 0);
    tick();
    chk("t1_rsp_vld", b0.rsp_valid, 4'b0100);
    chk("t1_rsp_dat", b0.rsp_data, 12'h3C0);
    chk("t1_busy_hi", b0.busy, 1);
    tick();
    chk("t1_busy_lo", b0.busy, 0);
    chk("t1_rsp_off", b0.rsp_valid, 0);
    chk("t1_rsp_hold", b0.rsp_data, 12'h3C0);

    // Round-robin with all requesters active for 8 cycles
    do_reset();
    for (int i = 0; i < N; i++) begin
      b0.req_a[i] = 12'h100 + 12'(i);
      b0.req_b[i] = 12'h200;
    end
    b0.req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      logic [N-1:0] er, ev;
      if (c == 8) b0.req_valid = '0;
      #1;
      er = (c < 8) ? 4'(1 << (c % 4)) : 4'b0;
      ev = (c >= 3 && c < 11) ? 4'(1 << ((c - 3) % 4)) : 4'b0;
      chk($sformatf("rr_ready%0d", c), b0.req_ready, er);
      chk($sformatf("rr_rsp%0d", c), b0.rsp_valid, ev);
      if (ev != '0) chk($sformatf("rr_data%0d", c), b0.rsp_data, 12'h100 + 12'((c - 3) % 4));
      tick();
    end

    // Spurious result with nothing outstanding
    spur0 = 1'b1;
    tick(); spur0 = 1'b0;
    chk("sp_err", b0.err, 1);
    chk("sp_rsp", b0.rsp_valid, 0);
    chk("sp_busy", b0.busy, 0);
    tick();
    chk("sp_err_sticky", b0.err, 1);
    chk("sp_rsp2", b0.rsp_valid, 0);

    // Reset with three operations in flight
    b0.req_valid = 4'b0111;
    tick(); tick(); tick();
    b0.req_valid = 4'hF;
    rst_n = 1'b0; #1;
    chk("mr_ready", b0.req_ready, 0);
    chk("mr_mvld",  b0.mul_valid_in, 0);
    chk("mr_mul_a", b0.mul_a, 0);
    chk("mr_mul_b", b0.mul_b, 0);
    chk("mr_rsp",   b0.rsp_valid, 0);
    chk("mr_data",  b0.rsp_data, 0);
    chk("mr_busy",  b0.busy, 0);
    chk("mr_err",   b0.err, 0);
    b0.req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mr_no_rsp%0d", c), b0.rsp_valid, 0);
    end
    b0.req_valid = 4'hF; #1;
    chk("mr_first_gnt", b0.req_ready, 4'b0001);
    b0.req_valid = '0;
    tick();
    repeat (4) tick();

    // Full stall on dut1 (DEPTH=2, MUL_LAT=3), requester 0 continuous
    fs_exp = 8'b0110_0011;
    b1.req_a[0] = 12'h0AB; b1.req_b[0] = 12'h155;
    b1.req_valid = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("fs_ready%0d", c), b1.req_ready[0], fs_exp[c]);
      if (c == 2) chk("fs_cnt", dut1.r_cnt, 2);
      if (c == 5) begin
        chk("fs_rsp", b1.rsp_valid, 4'b0001);
        chk("fs_data", b1.rsp_data, 12'h0AB);
      end
      tick();
    end
    b1.req_valid = '0;
    repeat (8) tick();
    chk("fs_drained", b1.busy, 0);

`ifdef FPMUL_ARB_STATS_EN
    do_reset();
    chk("st_rst", gcnt0, 0);
    b0.req_valid = 4'b0010; repeat (5) tick();
    b0.req_valid = 4'b1000; repeat (2) tick();
    b0.req_valid = '0; tick();
    chk("st_cnt0", gcnt0[0], 0);
    chk("st_cnt1", gcnt0[1], 5);
    chk("st_cnt2", gcnt0[2], 0);
    chk("st_cnt3", gcnt0[3], 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
